// File: rtl/cpu_pkg.sv
// Shared CPU core types: register names, bus timing states and ops.
// Imported by every core unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    REG_B, REG_C, REG_D, REG_E,
    REG_H, REG_L, REG_A, REG_F,
    REG_W, REG_Z,
    REG_SPH, REG_SPL,
    REG_PCH, REG_PCL
  } register_n_t;

  typedef enum logic [1:0] {
    T1, T2, T3, T4
  } t_state_t;

  typedef enum logic [1:0] {
    BUS_IDLE, BUS_READ, BUS_WRITE
  } bus_op_t;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  function automatic t_state_t t_next(
    input t_state_t t
  );
    t_state_t n;
    unique case (t)
      T1: n = T2;
      T2: n = T3;
      T3: n = T4;
      default: n = T1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bus_ctrl_mcycle_timer.sv
// Free-running T-state counter, four T-states per M-cycle.
// Freezes while bus_stall is high.
import cpu_pkg::*;

module mcycle_timer (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     bus_stall,
  output t_state_t t_state,
  output logic     m_start
);

  t_state_t t_q;
  logic     m_q;

  // advance T-state and register the T1 decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= T1;
      m_q <= 1'b0;
    end else if (!bus_stall) begin
      t_q <= t_next(t_q);
      m_q <= (t_q == T4);
    end
  end

  assign t_state = t_q;
  assign m_start = m_q & ~bus_stall;

endmodule

// File: rtl/bus_ctrl.sv
// M-cycle bus controller: single-byte reads and writes,
// read data forwarded to the register file in T4.
import cpu_pkg::*;

module bus_ctrl #(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_stall,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  register_n_t       req_dst,
  output logic              rf_write_r,
  output register_n_t       rf_write_reg_r,
  output logic [DATA_W-1:0] rf_data_in_r,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output t_state_t          t_state,
  output logic              m_start,
  output logic              done
);

  bus_op_t           op_q;
  bus_op_t           op_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wlat_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  register_n_t       dst_q;
  logic              adv;
  logic              t4;
  logic              accept;
  logic              fin;

  mcycle_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_stall (bus_stall),
    .t_state   (t_state),
    .m_start   (m_start)
  );

  assign adv       = ~bus_stall;
  assign t4        = (t_state == T4);
  assign req_ready = t4 & adv;
  assign accept    = req_valid & req_ready;
  assign fin       = t4 & adv;

  // op register, only moves at the edge ending T4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= BUS_IDLE;
    end else begin
      op_q <= op_d;
    end
  end

  // next op: accepted request, else idle
  always_comb begin
    op_d = op_q;
    if (req_ready) begin
      if (!req_valid) begin
        op_d = BUS_IDLE;
      end else if (req_write) begin
        op_d = BUS_WRITE;
      end else begin
        op_d = BUS_READ;
      end
    end
  end

  // request latches, write-data launch and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wlat_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dst_q   <= REG_B;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        wlat_q <= req_wdata;
        dst_q  <= req_dst;
      end
      if (adv && op_q == BUS_WRITE
          && t_state == T1) begin
        wdata_q <= wlat_q;
      end
      if (adv && op_q == BUS_READ
          && t_state == T3) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // strobes and completion decoded from op and T-state
  always_comb begin
    bus_rd     = 1'b0;
    bus_wr     = 1'b0;
    rf_write_r = 1'b0;
    done       = 1'b0;
    unique case (op_q)
      BUS_READ: begin
        bus_rd     = (t_state == T2)
                   | (t_state == T3);
        rf_write_r = fin;
        done       = fin;
      end
      BUS_WRITE: begin
        bus_wr = (t_state == T2)
               | (t_state == T3);
        done   = fin;
      end
      default: begin
        bus_rd = 1'b0;
      end
    endcase
  end

  assign rf_write_reg_r = rf_write_r ? dst_q : REG_B;
  assign rf_data_in_r   = rf_write_r ? rdata_q : '0;
  assign bus_addr       = addr_q;
  assign bus_wdata      = wdata_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed table-driven bench for bus_ctrl.
// One record per clock: inputs plus expected outputs.
module tb_bus_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_stall = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  register_n_t req_dst = REG_B;
  logic [7:0]  bus_rdata = '0;
  logic        req_ready;
  logic        rf_write_r;
  register_n_t rf_write_reg_r;
  logic [7:0]  rf_data_in_r;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  t_state_t    t_state;
  logic        m_start;
  logic        done;

  bus_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_stall      (bus_stall),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_dst        (req_dst),
    .rf_write_r     (rf_write_r),
    .rf_write_reg_r (rf_write_reg_r),
    .rf_data_in_r   (rf_data_in_r),
    .bus_addr       (bus_addr),
    .bus_rd         (bus_rd),
    .bus_wr         (bus_wr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .t_state        (t_state),
    .m_start        (m_start),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        va;
    logic        we;
    logic [15:0] a;
    logic [7:0]  wd;
    register_n_t dst;
    logic [7:0]  rd;
    t_state_t    t;
    logic        ms;
    logic        rdy;
    logic        brd;
    logic        bwr;
    logic [15:0] ea;
    logic [7:0]  ewd;
    logic        cw;
    logic        rfw;
    register_n_t rr;
    logic [7:0]  rdat;
    logic        dn;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic v(
    input logic st, input logic va, input logic we,
    input logic [15:0] a, input logic [7:0] wd,
    input register_n_t dst, input logic [7:0] rd,
    input t_state_t t, input logic ms, input logic rdy,
    input logic brd, input logic bwr,
    input logic [15:0] ea, input logic [7:0] ewd,
    input logic cw, input logic rfw,
    input register_n_t rr, input logic [7:0] rdat,
    input logic dn);
    vec_t r;
    r.st = st; r.va = va; r.we = we; r.a = a;
    r.wd = wd; r.dst = dst; r.rd = rd; r.t = t;
    r.ms = ms; r.rdy = rdy; r.brd = brd;
    r.bwr = bwr; r.ea = ea; r.ewd = ewd;
    r.cw = cw; r.rfw = rfw; r.rr = rr;
    r.rdat = rdat; r.dn = dn;
    tbl.push_back(r);
  endtask

  task automatic fill();
    // idle after reset
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,0,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T2,0,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T3,0,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T4,0,1,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,1,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T2,0,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T3,0,0,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    // c7: request read C123 -> Z
    v(0,1,0,16'hC123,8'h0,REG_Z,8'h0, T4,0,1,0,0,16'h0000,8'h00,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h5A, T1,1,0,0,0,16'hC123,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h5A, T2,0,0,1,0,16'hC123,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h5A, T3,0,0,1,0,16'hC123,8'h00,0,0,REG_B,8'h0,0);
    // c11: rf write Z=5A, request write 3C to FF80
    v(0,1,1,16'hFF80,8'h3C,REG_B,8'h5A, T4,0,1,0,0,16'hC123,8'h00,0,1,REG_Z,8'h5A,1);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,1,0,0,0,16'hFF80,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T2,0,0,0,1,16'hFF80,8'h3C,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T3,0,0,0,1,16'hFF80,8'h3C,1,0,REG_B,8'h0,0);
    // c15: write done, request read FF80 -> W
    v(0,1,0,16'hFF80,8'h0,REG_W,8'h0, T4,0,1,0,0,16'hFF80,8'h3C,1,0,REG_B,8'h0,1);
    v(0,0,0,16'h0,8'h0,REG_B,8'h3C, T1,1,0,0,0,16'hFF80,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h3C, T2,0,0,1,0,16'hFF80,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h3C, T3,0,0,1,0,16'hFF80,8'h00,0,0,REG_B,8'h0,0);
    // c19: rf write W=3C, request read 1234 -> A
    v(0,1,0,16'h1234,8'h0,REG_A,8'h3C, T4,0,1,0,0,16'hFF80,8'h00,0,1,REG_W,8'h3C,1);
    v(0,0,0,16'h0,8'h0,REG_B,8'h00, T1,1,0,0,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h00, T2,0,0,1,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    // c22-24: stalled in T3
    v(1,0,0,16'h0,8'h0,REG_B,8'h11, T3,0,0,1,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    v(1,0,0,16'h0,8'h0,REG_B,8'h11, T3,0,0,1,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    v(1,0,0,16'h0,8'h0,REG_B,8'h11, T3,0,0,1,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'hAA, T3,0,0,1,0,16'h1234,8'h00,0,0,REG_B,8'h0,0);
    // c26: single rf write A=AA, 7 clocks after accept
    v(0,0,0,16'h0,8'h0,REG_B,8'h00, T4,0,1,0,0,16'h1234,8'h00,0,1,REG_A,8'hAA,1);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,1,0,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T2,0,0,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T3,0,0,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    // c30-31: valid held while stalled in T4
    v(1,1,1,16'h0042,8'h99,REG_B,8'h0, T4,0,0,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    v(1,1,1,16'h0042,8'h99,REG_B,8'h0, T4,0,0,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    v(0,1,1,16'h0042,8'h99,REG_B,8'h0, T4,0,1,0,0,16'h1234,8'h3C,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,1,0,0,0,16'h0042,8'h00,0,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T2,0,0,0,1,16'h0042,8'h99,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T3,0,0,0,1,16'h0042,8'h99,1,0,REG_B,8'h0,0);
    // c36: stalled T4 suppresses done until c37
    v(1,0,0,16'h0,8'h0,REG_B,8'h0, T4,0,0,0,0,16'h0042,8'h99,1,0,REG_B,8'h0,0);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T4,0,1,0,0,16'h0042,8'h99,1,0,REG_B,8'h0,1);
    v(0,0,0,16'h0,8'h0,REG_B,8'h0, T1,1,0,0,0,16'h0042,8'h99,1,0,REG_B,8'h0,0);
  endtask

  task automatic apply_check(input int i);
    vec_t r;
    r = tbl[i];
    bus_stall = r.st;
    req_valid = r.va;
    req_write = r.we;
    req_addr  = r.a;
    req_wdata = r.wd;
    req_dst   = r.dst;
    bus_rdata = r.rd;
    #1;
    chk("t_state", i, t_state, r.t);
    chk("m_start", i, m_start, r.ms);
    chk("req_ready", i, req_ready, r.rdy);
    chk("bus_rd", i, bus_rd, r.brd);
    chk("bus_wr", i, bus_wr, r.bwr);
    chk("bus_addr", i, bus_addr, r.ea);
    if (r.cw) chk("bus_wdata", i, bus_wdata, r.ewd);
    chk("rf_write_r", i, rf_write_r, r.rfw);
    if (r.rfw) begin
      chk("rf_reg", i, rf_write_reg_r, r.rr);
      chk("rf_data", i, rf_data_in_r, r.rdat);
    end
    chk("done", i, done, r.dn);
  endtask

  initial begin
    fill();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_t", 0, t_state, T1);
    chk("rst_addr", 0, bus_addr, 16'h0);
    chk("rst_rd", 0, bus_rd, 1'b0);
    chk("rst_ms", 0, m_start, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply_check(i);
      @(negedge clk);
    end
    // reset asserted mid-read in T3
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h8000;
    req_dst   = REG_B;
    #1;
    chk("ar_ready", 41, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    bus_rdata = 8'h77;
    #1;
    chk("ar_addr", 42, bus_addr, 16'h8000);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_rd_t3", 44, bus_rd, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_clr_t", 44, t_state, T1);
    chk("ar_clr_rd", 44, bus_rd, 1'b0);
    chk("ar_clr_addr", 44, bus_addr, 16'h0);
    chk("ar_clr_wd", 44, bus_wdata, 8'h0);
    chk("ar_clr_rfw", 44, rf_write_r, 1'b0);
    chk("ar_clr_done", 44, done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("post_t", k, t_state, k);
      chk("post_rd", k, bus_rd, 1'b0);
      chk("post_rfw", k, rf_write_r, 1'b0);
      chk("post_done", k, done, 1'b0);
      chk("post_addr", k, bus_addr, 16'h0);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

CPU memory-bus controller that sits directly upstream of `register_file`. It turns single-byte read/write requests from the core sequencer into Game Boy M-cycle bus timing of four T-states per M-cycle. Read data is delivered into the register file through its 8-bit write port, typically into Z or W. It also owns the free-running T-state counter the rest of the core uses to align micro-ops.

## Interface
- `ADDR_W`, 16: bus address width.
- `DATA_W`, 8: bus data width; must equal the register file 8-bit port width.

- `clk`  in  1  core clock, one T-state per cycle.
- `rst_n`  in  1  reset; asynchronous, active-low; single clock domain.
- `bus_stall`  in  1  freeze request (DMA/halt); holds all state while high.
- `req_valid`  in  1  sequencer has an access for the next M-cycle.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  access address.
- `req_wdata`  in  DATA_W  write data.
- `req_dst`  in  register_n_t  destination register for read data.
- `rf_write_r`  out  1  to register file `write_r`.
- `rf_write_reg_r`  out  register_n_t  to register file `write_reg_r`.
- `rf_data_in_r`  out  DATA_W  to register file `data_in_r`.
- `bus_addr`  out  ADDR_W  external address.
- `bus_rd`  out  1  read strobe.
- `bus_wr`  out  1  write strobe.
- `bus_wdata`  out  DATA_W  write data.
- `bus_rdata`  in  DATA_W  read data; valid by end of T3.
- `t_state`  out  t_state_t  current T-state (T1..T4).
- `m_start`  out  1  high during T1 of every non-stalled M-cycle.
- `done`  out  1  one-cycle pulse in T4 of a completed access.

## Operation
- T-state counter runs T1→T2→T3→T4→T1 continuously and advances only when `bus_stall`=0.
- Op state `bus_op_t` is one of `BUS_IDLE`, `BUS_READ`, or `BUS_WRITE`, and changes only at the edge ending T4.
- `req_ready` = (`t_state`==T4) & ~`bus_stall`. A request accepted at the end of T4 becomes the op of the next M-cycle. `req_addr`, `req_wdata`, `req_dst`, and `req_write` are latched at acceptance. No request accepted → next op is `BUS_IDLE`.
- READ M-cycle:
  - `bus_addr` is driven from T1.
  - `bus_rd` is high in T2–T3.
  - `bus_rdata` is captured at the edge ending T3.
  - In T4: `rf_write_r`=1, `rf_write_reg_r`=latched dst, `rf_data_in_r`=captured byte, `done`=1.
- WRITE M-cycle:
  - `bus_addr` is driven from T1.
  - `bus_wdata` is driven T2–T4.
  - `bus_wr` is high T2–T3.
  - `done`=1 in T4.
  - `rf_write_r`=0 for the whole M-cycle.
- IDLE M-cycle: `bus_rd`=`bus_wr`=`rf_write_r`=`done`=0; `bus_addr` and `bus_wdata` hold their last values.
- Stall:
  - All registers hold.
  - `rf_write_r`, `done`, `req_ready`, and `m_start` are forced 0 while stalled.
  - `bus_rd`/`bus_wr` keep their pre-stall level.
  - A T4 register-file write is issued only on a non-stalled T4 cycle, exactly once.
- Reset (async, mid-access included):
  - Values forced: `t_state`=T1, op=`BUS_IDLE`, `bus_addr`=0, `bus_wdata`=0, all strobes 0, `rf_*`=0, `done`=0, `m_start`=0.
  - The aborted access produces no register-file write.
  - The first M-cycle after release is IDLE.

## Timing
- Read latency: accept at edge ending T4 of M-cycle N; byte is stored in the register file at edge ending T4 of N+1, i.e. 4 clocks (plus stall cycles).
- Back-to-back: a request accepted in the T4 of an active access yields zero idle T-states between accesses (one access per M-cycle).
- `done` and `rf_write_r` coincide (read) in the same T4 cycle; `m_start` is a registered decode of `t_state`.
- Outputs to the register file are combinational from registered state only; no input-to-output combinational path except `bus_stall` gating.

## Structure
- Add to `cpu_pkg`:
  - `t_state_t` enum {T1,T2,T3,T4}, 2 bits.
  - `bus_op_t` enum {BUS_IDLE,BUS_READ,BUS_WRITE}.
- `register_n_t` is reused from `cpu_pkg`.
- Sub-module `mcycle_timer`: T-state counter with stall and async active-low reset; outputs `t_state` and `m_start`. `bus_ctrl` contains the op FSM, request latches, and read-data capture.

## Test plan
- Reset release, no requests → `t_state` cycles T1..T4 every 4 clks, `m_start` every 4th clk, strobes 0, `bus_addr`=0x0000.
- Read `req_addr`=0xC123, `req_dst`=Z, `bus_rdata`=0x5A → `bus_rd` high T2–T3 with `bus_addr`=0xC123; T4: `rf_write_r`=1, reg=Z, data=0x5A; `done` 1 clk; latency 4 clks from acceptance.
- Write 0x3C to 0xFF80 followed immediately by read 0xFF80 into W → two consecutive M-cycles. First: `bus_wr` T2–T3, `bus_wdata`=0x3C, no rf write. Second: rf write W=0x3C.
- `bus_stall` high 3 clks during T3 of a read → counter frozen, `bus_rd` held, exactly one `rf_write_r` pulse after release, latency 7 clks.
- `req_valid` held high with `bus_stall` asserted in T4 → `req_ready`=0, request not accepted until first non-stalled T4.
- `rst_n` low asynchronously in T3 of a read to B → immediate output clear, no write to B, first post-reset M-cycle IDLE.
